// File: rtl/robo_wall_ctrl.sv
// robo_wall_ctrl: wall-following robot controller.
// Selectable left/right-hand rule, timed turns with a latched rotation
// direction, corner recovery, barrier removal with a timeout fault,
// standby/resume, and a saturating forward-step counter.
module robo_wall_ctrl #(
   parameter int TURN_CYCLES = 4,
   parameter int REMOVE_MAX  = 8,
   parameter int STEP_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              head,
   input  logic              left,
   input  logic              right,
   input  logic              under,
   input  logic              barrier,
   input  logic              hand_sel,
   input  logic              resume,
   output logic              avancar,
   output logic              girar,
   output logic              girar_dir,
   output logic              remover,
   output logic [2:0]        estado,
   output logic [STEP_W-1:0] passos,
   output logic              falha
);

   localparam int CNT_MAX = (TURN_CYCLES > REMOVE_MAX) ? TURN_CYCLES : REMOVE_MAX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] REMOVE_LAST = CNT_W'(REMOVE_MAX - 1);

   localparam logic [2:0] ST_SEEK    = 3'd0;
   localparam logic [2:0] ST_TURN    = 3'd1;
   localparam logic [2:0] ST_FOLLOW  = 3'd2;
   localparam logic [2:0] ST_INIT    = 3'd3;
   localparam logic [2:0] ST_REMOVE  = 3'd4;
   localparam logic [2:0] ST_STANDBY = 3'd5;
   localparam logic [2:0] ST_CORNER  = 3'd6;
   localparam logic [2:0] ST_FAULT   = 3'd7;

   logic [2:0]        state_r;
   logic [2:0]        state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              dir_r;
   logic              dir_nxt_s;
   logic              side_s;
   logic [STEP_W-1:0] passos_r;
   logic              avancar_r;
   logic              girar_r;
   logic              remover_r;
   logic              falha_r;

   // Common navigation decision once a turn, corner or removal is finished.
   function automatic logic [2:0] nav_exit(input logic head_i, input logic side_i);
      if (head_i) begin
         nav_exit = ST_TURN;
      end else if (side_i) begin
         nav_exit = ST_FOLLOW;
      end else begin
         nav_exit = ST_SEEK;
      end
   endfunction

   // Next-state, phase counter and rotation direction decision.
   always_comb begin
      side_s      = hand_sel ? right : left;
      state_nxt_s = state_r;
      cnt_nxt_s   = {CNT_W{1'b0}};
      case (state_r)
         ST_INIT, ST_SEEK, ST_FOLLOW: begin
            if (under) begin
               state_nxt_s = ST_STANDBY;
            end else if (barrier) begin
               state_nxt_s = ST_REMOVE;
            end else if (head) begin
               state_nxt_s = ST_TURN;
            end else if (state_r == ST_FOLLOW) begin
               state_nxt_s = side_s ? ST_FOLLOW : ST_CORNER;
            end else if (side_s) begin
               state_nxt_s = ST_FOLLOW;
            end else begin
               state_nxt_s = ST_SEEK;
            end
         end
         ST_TURN, ST_CORNER: begin
            if (under) begin
               state_nxt_s = ST_STANDBY;
            end else if (barrier) begin
               state_nxt_s = ST_REMOVE;
            end else if (cnt_r == TURN_LAST) begin
               state_nxt_s = nav_exit(head, side_s);
            end else begin
               state_nxt_s = state_r;
               cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
            end
         end
         ST_REMOVE: begin
            if (under) begin
               state_nxt_s = ST_STANDBY;
            end else if (!barrier) begin
               state_nxt_s = nav_exit(head, side_s);
            end else if (cnt_r == REMOVE_LAST) begin
               state_nxt_s = ST_FAULT;
            end else begin
               state_nxt_s = ST_REMOVE;
               cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
            end
         end
         ST_STANDBY: begin
            if (resume && !under) begin
               state_nxt_s = ST_INIT;
            end else begin
               state_nxt_s = ST_STANDBY;
            end
         end
         ST_FAULT: begin
            state_nxt_s = ST_FAULT;
         end
         default: begin
            state_nxt_s = ST_INIT;
         end
      endcase

      // Direction is latched on entry and held while rotating (a restarted
      // turn keeps its direction); it reads 0 whenever the robot is not turning.
      if (state_nxt_s == ST_TURN) begin
         dir_nxt_s = (state_r == ST_TURN) ? dir_r : ~hand_sel;
      end else if (state_nxt_s == ST_CORNER) begin
         dir_nxt_s = (state_r == ST_CORNER) ? dir_r : hand_sel;
      end else begin
         dir_nxt_s = 1'b0;
      end
   end

   // State, counter, direction and registered Moore output decode.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r   <= ST_INIT;
         cnt_r     <= {CNT_W{1'b0}};
         dir_r     <= 1'b0;
         avancar_r <= 1'b0;
         girar_r   <= 1'b0;
         remover_r <= 1'b0;
         falha_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         dir_r     <= dir_nxt_s;
         avancar_r <= (state_nxt_s == ST_SEEK) || (state_nxt_s == ST_FOLLOW);
         girar_r   <= (state_nxt_s == ST_TURN) || (state_nxt_s == ST_CORNER);
         remover_r <= (state_nxt_s == ST_REMOVE);
         falha_r   <= (state_nxt_s == ST_FAULT);
      end
   end

   // Saturating count of clock edges spent moving forward.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         passos_r <= {STEP_W{1'b0}};
      end else if (((state_r == ST_SEEK) || (state_r == ST_FOLLOW)) &&
                   (passos_r != {STEP_W{1'b1}})) begin
         passos_r <= passos_r + STEP_W'(1'b1);
      end else begin
         passos_r <= passos_r;
      end
   end

   assign avancar   = avancar_r;
   assign girar     = girar_r;
   assign girar_dir = dir_r;
   assign remover   = remover_r;
   assign falha     = falha_r;
   assign estado    = state_r;
   assign passos    = passos_r;

endmodule

// File: tb/tb_robo_wall_ctrl.sv
// Self-checking bench for robo_wall_ctrl: table of stimulus/expectation
// records run through a scoreboard queue, plus hand-written reset and
// saturation sequences on a second instance with a 4-bit step counter.
module tb_robo_wall_ctrl;

   logic        clock;
   logic        reset;
   logic        head, left, right, under, barrier, hand_sel, resume;
   logic        avancar, girar, girar_dir, remover, falha;
   logic [2:0]  estado;
   logic [15:0] passos;
   logic        s_avancar, s_girar, s_girar_dir, s_remover, s_falha;
   logic [2:0]  s_estado;
   logic [3:0]  s_passos;

   int n_chk  = 0;
   int n_fail = 0;

   robo_wall_ctrl #(.TURN_CYCLES(4), .REMOVE_MAX(8), .STEP_W(16)) u_dut (
      .clock(clock), .reset(reset), .head(head), .left(left), .right(right),
      .under(under), .barrier(barrier), .hand_sel(hand_sel), .resume(resume),
      .avancar(avancar), .girar(girar), .girar_dir(girar_dir), .remover(remover),
      .estado(estado), .passos(passos), .falha(falha));

   robo_wall_ctrl #(.TURN_CYCLES(4), .REMOVE_MAX(8), .STEP_W(4)) u_sat (
      .clock(clock), .reset(reset), .head(head), .left(left), .right(right),
      .under(under), .barrier(barrier), .hand_sel(hand_sel), .resume(resume),
      .avancar(s_avancar), .girar(s_girar), .girar_dir(s_girar_dir), .remover(s_remover),
      .estado(s_estado), .passos(s_passos), .falha(s_falha));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // in  = {hand_sel, head, left, right, under, barrier, resume}
   // exp = {estado[2:0], avancar, girar, girar_dir, remover, falha}
   typedef struct {
      bit          rst_before;
      logic [6:0]  in;
      logic [7:0]  exp;
      int          p;
      string       nm;
   } vec_t;

   localparam logic [7:0] E_SEEK  = {3'd0, 5'b10000};
   localparam logic [7:0] E_TCW   = {3'd1, 5'b01100};
   localparam logic [7:0] E_TCCW  = {3'd1, 5'b01000};
   localparam logic [7:0] E_FOLL  = {3'd2, 5'b10000};
   localparam logic [7:0] E_INIT  = {3'd3, 5'b00000};
   localparam logic [7:0] E_REM   = {3'd4, 5'b00010};
   localparam logic [7:0] E_STBY  = {3'd5, 5'b00000};
   localparam logic [7:0] E_CCCW  = {3'd6, 5'b01000};
   localparam logic [7:0] E_FAULT = {3'd7, 5'b00001};

   vec_t vecs[$];
   vec_t sb[$];

   function automatic void add(input string nm, input bit rb, input logic [6:0] in,
                               input logic [7:0] ex, input int p);
      vec_t v;
      v.rst_before = rb;
      v.in         = in;
      v.exp        = ex;
      v.p          = p;
      v.nm         = nm;
      vecs.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive_in(input logic [6:0] in);
      {hand_sel, head, left, right, under, barrier, resume} = in;
   endtask

   // Pulse reset across one rising edge; outputs must clear without a clock.
   task automatic do_reset();
      drive_in(7'b0000000);
      reset = 1'b1;
      #1;
      check("reset outputs", {estado, avancar, girar, girar_dir, remover, falha}, E_INIT);
      check("reset passos", passos, 32'd0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      vec_t cur;
      reset = 1'b1;
      drive_in(7'b0000000);

      // Left-hand follow: INIT -> FOLLOW, passos reaches 9 after 10 cycles.
      for (int i = 0; i < 10; i++) add("lh follow", (i == 0), 7'b0010000, E_FOLL, i);
      // Blocked turn, left-hand rule: clockwise for 4 cycles then FOLLOW.
      add("lh turn start", 1'b0, 7'b0110000, E_TCW, 10);
      for (int i = 0; i < 3; i++) add("lh turn hold", 1'b0, 7'b0010000, E_TCW, 10);
      add("lh turn done", 1'b0, 7'b0010000, E_FOLL, 10);
      // Right-hand rule: counter-clockwise turn, restart on head at completion,
      // hand_sel flip mid-turn must not change direction.
      add("rh follow", 1'b0, 7'b1001000, E_FOLL, 11);
      add("rh turn start", 1'b0, 7'b1101000, E_TCCW, 12);
      for (int i = 0; i < 3; i++) add("rh turn hold", 1'b0, 7'b1001000, E_TCCW, 12);
      add("rh turn restart", 1'b0, 7'b1101000, E_TCCW, 12);
      for (int i = 0; i < 3; i++) add("rh dir kept", 1'b0, 7'b0011000, E_TCCW, 12);
      add("rh turn done", 1'b0, 7'b0011000, E_FOLL, 12);
      // Corner recovery: wall lost, toward (ccw) for 4 cycles then SEEK.
      add("corner start", 1'b0, 7'b0000000, E_CCCW, 13);
      for (int i = 0; i < 3; i++) add("corner hold", 1'b0, 7'b0000000, E_CCCW, 13);
      add("corner done", 1'b0, 7'b0000000, E_SEEK, 13);
      add("seek stay", 1'b0, 7'b0000000, E_SEEK, 14);
      // Removal success: barrier for 3 cycles, then back to FOLLOW.
      add("seek to follow", 1'b0, 7'b0010000, E_FOLL, 15);
      for (int i = 0; i < 3; i++) add("remove short", 1'b0, 7'b0010010, E_REM, 16);
      add("remove exit", 1'b0, 7'b0010000, E_FOLL, 16);
      // Removal timeout: 8 cycles of remover, then sticky FAULT.
      for (int i = 0; i < 8; i++) add("remove long", 1'b0, 7'b0010010, E_REM, 17);
      add("fault entry", 1'b0, 7'b0010010, E_FAULT, 17);
      add("fault under", 1'b0, 7'b0000100, E_FAULT, 17);
      add("fault resume", 1'b0, 7'b0000001, E_FAULT, 17);
      add("fault head", 1'b0, 7'b0100000, E_FAULT, 17);
      // Priority: under beats barrier in TURN; resume needs under low.
      add("init to turn", 1'b1, 7'b0100000, E_TCW, 0);
      add("under+barrier", 1'b0, 7'b0000110, E_STBY, 0);
      add("resume blocked", 1'b0, 7'b0000101, E_STBY, 0);
      add("resume", 1'b0, 7'b0000001, E_INIT, 0);
      add("init to seek", 1'b0, 7'b0000000, E_SEEK, 0);
      for (int i = 1; i <= 20; i++) add("seek count", 1'b0, 7'b0000000, E_SEEK, i);

      @(negedge clock);
      foreach (vecs[i]) begin
         if (vecs[i].rst_before) do_reset();
         drive_in(vecs[i].in);
         sb.push_back(vecs[i]);
         @(negedge clock);
         cur = sb.pop_front();
         check(cur.nm, {estado, avancar, girar, girar_dir, remover, falha}, cur.exp);
         if (cur.p >= 0) check({cur.nm, " passos"}, passos, cur.p);
      end

      // 4-bit counter saw 20 forward edges and must hold at 15.
      check("sat passos", s_passos, 32'd15);
      check("sat state", s_estado, 32'd0);

      // Asynchronous reset in the middle of a turn.
      drive_in(7'b0100000);
      @(negedge clock);
      check("pre-reset turn", {estado, avancar, girar, girar_dir, remover, falha}, E_TCW);
      #2;
      reset = 1'b1;
      #1;
      check("async reset outs", {estado, avancar, girar, girar_dir, remover, falha}, E_INIT);
      check("async reset passos", passos, 32'd0);
      check("async reset sat passos", s_passos, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      drive_in(7'b0010000);
      @(negedge clock);
      check("init one cycle", {estado, avancar, girar, girar_dir, remover, falha}, E_FOLL);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/robo_wall_ctrl.md
# robo_wall_ctrl

Parametrised wall-following robot controller. It is the next-generation successor of the single-rule robot FSM. Adds selectable left/right-hand wall rule, timed multi-cycle turns with latched direction, a corner-recovery turn, a removal timeout with fault latch, resume from standby, and a saturating step counter. It sits between the sensor front-end and the motor/actuator drivers of the robot model.

## Interface
- TURN_CYCLES, 4: cycles `girar` is held per 90° turn; must be ≥1
- REMOVE_MAX, 8: maximum cycles in removal before fault; must be ≥1
- STEP_W, 16: width of `passos`
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock
- head  in  1  obstacle directly ahead
- left  in  1  wall on left side
- right  in  1  wall on right side
- under  in  1  end-mark beneath robot; forces standby
- barrier  in  1  removable barrier ahead
- hand_sel  in  1  0 = left-hand rule (wall tracked with `left`), 1 = right-hand rule (`right`)
- resume  in  1  leave STANDBY
- avancar  out  1  move forward
- girar  out  1  rotate
- girar_dir  out  1  1 = clockwise (right), 0 = counter-clockwise
- remover  out  1  actuate remover
- estado  out  3  current state code
- passos  out  STEP_W  saturating count of forward cycles
- falha  out  1  removal fault, sticky until reset

## Operation
- `side` = hand_sel ? right : left, evaluated each cycle.
- Away direction = ~hand_sel; toward direction = hand_sel.
- State codes:
  - SEEK=0, TURN=1, FOLLOW=2, INIT=3, REMOVE=4, STANDBY=5, CORNER=6, FAULT=7.
- Moore outputs, decoded from the state register only:
  - avancar=1 in SEEK and FOLLOW.
  - girar=1 in TURN and CORNER.
  - remover=1 in REMOVE.
  - falha=1 in FAULT.
  - All other outputs are 0.
- Priority in INIT, SEEK, TURN, FOLLOW, CORNER and REMOVE: under=1 goes to STANDBY first; barrier=1 goes to REMOVE second (except in REMOVE itself, which handles barrier below).
- INIT: head goes to TURN; else side goes to FOLLOW; else SEEK.
- SEEK: head goes to TURN; side goes to FOLLOW; else stay.
- FOLLOW: head goes to TURN; side=0 goes to CORNER; else stay.
- TURN:
  - On entry, latch girar_dir = away direction and clear cnt.
  - Increment cnt each cycle.
  - When cnt = TURN_CYCLES-1: head=1 restarts TURN (cnt cleared, direction kept); side=1 goes to FOLLOW; else SEEK.
- CORNER:
  - On entry, latch girar_dir = toward direction and clear cnt.
  - When cnt = TURN_CYCLES-1: head=1 goes to TURN; side=1 goes to FOLLOW; else SEEK.
- REMOVE:
  - Clear cnt on entry.
  - barrier=0 exits: head goes to TURN, side goes to FOLLOW, else SEEK.
  - barrier=1 with cnt = REMOVE_MAX-1 goes to FAULT.
  - Otherwise increment cnt and stay.
- STANDBY: resume=1 and under=0 goes to INIT; else stay.
- FAULT: terminal; only reset leaves it.
- hand_sel changes take effect on the next decision. girar_dir is not altered mid-turn.
- passos:
  - Increments by 1 on every clock edge where the state is SEEK or FOLLOW.
  - Saturates at 2^STEP_W-1; never wraps.
- cnt width is $clog2(max(TURN_CYCLES, REMOVE_MAX)+1).

## Timing
- Reset, asynchronous: state=INIT, cnt=0, passos=0, girar_dir=0, and all outputs 0 immediately.
- INIT lasts exactly one cycle after reset deassertion when no preemption occurs.
- Inputs are sampled at the rising edge. Outputs reflect the decision one cycle later, so sensor-to-actuator latency is 1 clock.
- TURN and CORNER hold girar=1 for exactly TURN_CYCLES consecutive cycles unless preempted by under or barrier.
- REMOVE holds remover=1 for at most REMOVE_MAX cycles. FAULT appears on the edge after the REMOVE_MAX-th cycle if barrier is still 1.
- Simultaneous events:
  - under beats barrier, and both beat turn completion.
  - Completion with head=1 and side=1 takes the head branch.
- Reset mid-turn or mid-removal aborts immediately. Counters clear; passos clears.

## Test plan
- Left-hand follow:
  - Stimulus: reset, hand_sel=0, left=1, others 0 for 10 cycles.
  - Required: INIT→FOLLOW; avancar=1 from cycle 2; passos=9 after 10 cycles.
- Blocked turn:
  - Stimulus: in FOLLOW, head=1 for 1 cycle, then head=0, left=1.
  - Required: girar=1 and girar_dir=1 for exactly 4 cycles, then FOLLOW.
  - Repeat with hand_sel=1 and right=1: girar_dir=0.
- Corner:
  - Stimulus: in FOLLOW, left drops to 0 and stays 0.
  - Required: CORNER with girar_dir=0 for 4 cycles, then SEEK with avancar=1.
- Removal:
  - Stimulus: barrier=1 for 3 cycles, then 0, with left=1.
  - Required: remover=1 for 3 cycles, then FOLLOW.
  - Stimulus: barrier held at 1.
  - Required: remover=1 for 8 cycles, then estado=7 and falha=1, held until reset.
- Standby/resume and priority:
  - Stimulus: under=1 and barrier=1 together while in TURN.
  - Required: STANDBY with all outputs 0.
  - Stimulus: resume=1 while under=1.
  - Required: stays in STANDBY.
  - Stimulus: under=0 and resume=1.
  - Required: INIT, then SEEK.
- Saturation and async reset:
  - Stimulus: STEP_W=4, SEEK for 20 cycles.
  - Required: passos stops at 15.
  - Stimulus: assert reset mid-cycle during TURN.
  - Required: outputs 0 and passos=0 before the next edge.
